// File: rtl/vedic_mul_seq_ctrl.sv
// Sequenced 8x8 multiplier reusing one vedic_4x4 core over four steps.
// Define VEDIC_MUL_SIGNED_EN for two's-complement operands and product.

module vedic_4x4 (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] p
);
    logic [3:0] q_ll;
    logic [3:0] q_hl;
    logic [3:0] q_lh;
    logic [3:0] q_hh;

    // Urdhva-tiryakbhyam on 2-bit digits: vertical and crosswise terms summed.
    assign q_ll = {2'b00, x[1:0]} * {2'b00, y[1:0]};
    assign q_hl = {2'b00, x[3:2]} * {2'b00, y[1:0]};
    assign q_lh = {2'b00, x[1:0]} * {2'b00, y[3:2]};
    assign q_hh = {2'b00, x[3:2]} * {2'b00, y[3:2]};

    assign p = {4'h0, q_ll} + {2'b00, q_hl, 2'b00} + {2'b00, q_lh, 2'b00} + {q_hh, 4'h0};
endmodule

module vedic_mul_seq_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);
    typedef enum logic [2:0] {IDLE, MUL0, MUL1, MUL2, MUL3, DONE} state_t;

    state_t      state;
    state_t      state_next;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc;
    logic [3:0]  core_x;
    logic [3:0]  core_y;
    logic [7:0]  core_p;
    logic [15:0] pp_shifted;
    logic [15:0] acc_sum;
    logic [15:0] result;
    logic [7:0]  a_load;
    logic [7:0]  b_load;

`ifdef VEDIC_MUL_SIGNED_EN
    logic neg_q;

    // Magnitudes fit in 8 bits unsigned, including |-128| = 128.
    assign a_load = a[7] ? (~a + 8'd1) : a;
    assign b_load = b[7] ? (~b + 8'd1) : b;
    assign result = neg_q ? (~acc_sum + 16'd1) : acc_sum;
`else
    assign a_load = a;
    assign b_load = b;
    assign result = acc_sum;
`endif

    vedic_4x4 u_core (
        .x (core_x),
        .y (core_y),
        .p (core_p)
    );

    always_comb begin
        core_x = a_q[3:0];
        core_y = b_q[3:0];
        case (state)
            MUL1:    core_x = a_q[7:4];
            MUL2:    core_y = b_q[7:4];
            MUL3: begin
                core_x = a_q[7:4];
                core_y = b_q[7:4];
            end
            default: ;
        endcase
    end

    always_comb begin
        pp_shifted = {8'h00, core_p};
        case (state)
            MUL1, MUL2: pp_shifted = {4'h0, core_p, 4'h0};
            MUL3:       pp_shifted = {core_p, 8'h00};
            default:    ;
        endcase
    end

    assign acc_sum = acc + pp_shifted;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = MUL0;
            MUL0:    state_next = MUL1;
            MUL1:    state_next = MUL2;
            MUL2:    state_next = MUL3;
            MUL3:    state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Operands are only captured in IDLE, so in_valid during a run is harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= 8'h00;
            b_q     <= 8'h00;
            acc     <= 16'h0000;
            product <= 16'h0000;
`ifdef VEDIC_MUL_SIGNED_EN
            neg_q   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= a_load;
                        b_q <= b_load;
                        acc <= 16'h0000;
`ifdef VEDIC_MUL_SIGNED_EN
                        neg_q <= a[7] ^ b[7];
`endif
                    end
                end
                MUL0, MUL1, MUL2: acc <= acc_sum;
                MUL3: begin
                    acc     <= acc_sum;
                    product <= result;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
endmodule
